// File: rtl/key_event_pkg.sv
// Shared types and widths for the key event generator.
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } key_state_e;

  localparam int unsigned PRESS_CNT_W = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Hold timer: synchronous clear/increment with terminal compares for the
// long-press and auto-repeat thresholds.
module key_hold_timer #(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic long_done_o,
  output logic rep_done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign long_done_o = (cnt_q == CNT_W'(LONG_CYCLES - 1));
  assign rep_done_o  = (cnt_q == CNT_W'(REPEAT_CYCLES - 1));

endmodule

// File: rtl/key_event_gen.sv
// Key event generator: turns a debounced button level into press, release,
// long-press and auto-repeat pulses plus a held flag and a press counter.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   level_in,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_pulse,
  output logic                   repeat_pulse,
  output logic                   held,
  output logic [PRESS_CNT_W-1:0] press_count
);

  key_state_e             state_q, state_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   long_q, long_d;
  logic                   rep_q, rep_d;
  logic                   held_q, held_d;
  logic [PRESS_CNT_W-1:0] count_q, count_d;

  logic tmr_clr;
  logic tmr_inc;
  logic long_done;
  logic rep_done;

  key_hold_timer #(
    .LONG_CYCLES   (LONG_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk_i       (clk),
    .rst_i       (reset),
    .clr_i       (tmr_clr),
    .inc_i       (tmr_inc),
    .long_done_o (long_done),
    .rep_done_o  (rep_done)
  );

  // Next state, timer control and next pulse values; release is checked
  // before the thresholds so it wins when both coincide.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (level_in) begin
          state_d = ST_PRESSED;
          tmr_clr = 1'b1;
          press_d = 1'b1;
          count_d = count_q + PRESS_CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!level_in) begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
          rel_d   = 1'b1;
        end else if (long_done) begin
          state_d = ST_REPEATING;
          tmr_clr = 1'b1;
          long_d  = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_REPEATING: begin
        if (!level_in) begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
          rel_d   = 1'b1;
        end else if (rep_done) begin
          tmr_clr = 1'b1;
          rep_d   = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
    held_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
      count_q <= count_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_q;
  assign held          = held_q;
  assign press_count   = count_q;

endmodule
